// File: rtl/systolic_link_pkg.sv
// Shared constants, ctrl-word layout and helpers for the systolic link host.
package systolic_link_pkg;

    localparam int BEATS   = 16;
    localparam int NIB     = 4;
    localparam int FRAME_W = 64;
    localparam int CTRL_W  = 16;

    localparam int CTRL_ADDR_HI = 15;
    localparam int CTRL_ADDR_LO = 8;
    localparam int CTRL_WR      = 5;
    localparam int CTRL_FV      = 4;
    localparam int CTRL_PAR     = 0;

    localparam logic [7:0] ADR_STATE = 8'h01;
    localparam logic [7:0] ADR_A     = 8'h02;
    localparam logic [7:0] ADR_B     = 8'h04;
    localparam logic [7:0] ADR_C0    = 8'h08;
    localparam logic [7:0] ADR_PIPE0 = 8'h10;

    function automatic logic [CTRL_W-1:0] mk_ctrl(
        input logic [7:0] addr,
        input logic       wr,
        input logic       fv
    );
        logic [CTRL_W-1:0] c;
        c = '0;
        c[CTRL_ADDR_HI:CTRL_ADDR_LO] = addr;
        c[CTRL_WR] = wr;
        c[CTRL_FV] = fv;
        return c;
    endfunction

endpackage

// File: rtl/systolic_link_host_deser.sv
// RX side: nibble deserialiser, frame capture and saturating overrun count.
// SYSTOLIC_LINK_PARITY_EN adds the rx_perr parity-error flag.
module slink_deser
    import systolic_link_pkg::*;
#(
    parameter int OVF_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cap,
    input  logic [NIB-1:0]     ser_din,
    input  logic               ser_cin,
    input  logic               rx_ready,
    output logic               rx_valid,
    output logic [FRAME_W-1:0] rx_data,
    output logic [CTRL_W-1:0]  rx_ctrl,
`ifdef SYSTOLIC_LINK_PARITY_EN
    output logic               rx_perr,
`endif
    output logic [OVF_W-1:0]   rx_ovf
);

    logic [FRAME_W-NIB-1:0] sh_q, sh_d;
    logic [CTRL_W-2:0]      csh_q, csh_d;
    logic [FRAME_W-1:0]     data_q, data_d, frm_data;
    logic [CTRL_W-1:0]      ctrl_q, ctrl_d, frm_ctrl;
    logic [OVF_W-1:0]       ovf_q, ovf_d;
    logic                   valid_q, valid_d;
    logic                   skip_q, skip_d;
`ifdef SYSTOLIC_LINK_PARITY_EN
    logic                   perr_q, perr_d;
`endif

    always_comb begin
        sh_d     = {sh_q[FRAME_W-2*NIB-1:0], ser_din};
        csh_d    = {csh_q[CTRL_W-3:0], ser_cin};
        frm_data = {sh_q, ser_din};
        frm_ctrl = {csh_q, ser_cin};
        data_d   = data_q;
        ctrl_d   = ctrl_q;
        ovf_d    = ovf_q;
        skip_d   = skip_q;
        valid_d  = valid_q;
`ifdef SYSTOLIC_LINK_PARITY_EN
        perr_d   = perr_q;
`endif
        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
        // The tile is still flushing zeros during the first block after reset.
        if (cap) begin
            if (skip_q) begin
                skip_d = 1'b0;
            end else begin
                valid_d = 1'b1;
                data_d  = frm_data;
                ctrl_d  = frm_ctrl;
`ifdef SYSTOLIC_LINK_PARITY_EN
                perr_d  = ^{frm_data, frm_ctrl};
`endif
                if (valid_q && !rx_ready && (ovf_q != '1)) begin
                    ovf_d = ovf_q + OVF_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_q    <= '0;
            csh_q   <= '0;
            data_q  <= '0;
            ctrl_q  <= '0;
            ovf_q   <= '0;
            valid_q <= 1'b0;
            skip_q  <= 1'b1;
`ifdef SYSTOLIC_LINK_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            sh_q    <= sh_d;
            csh_q   <= csh_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            skip_q  <= skip_d;
`ifdef SYSTOLIC_LINK_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    assign rx_valid = valid_q;
    assign rx_data  = data_q;
    assign rx_ctrl  = ctrl_q;
    assign rx_ovf   = ovf_q;
`ifdef SYSTOLIC_LINK_PARITY_EN
    assign rx_perr  = perr_q;
`endif

endmodule

// File: rtl/systolic_link_host.sv
// Host endpoint of the nibble-serial systolic tile port: TX holding/shift, RX via slink_deser.
// SYSTOLIC_LINK_PARITY_EN enables even parity in ctrl[0] and the rx_perr output.
module systolic_link_host
    import systolic_link_pkg::*;
#(
    parameter int         OVF_W    = 8,
    parameter logic [7:0] IDLE_ADR = 8'h00
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tx_valid,
    output logic               tx_ready,
    input  logic [FRAME_W-1:0] tx_data,
    input  logic [7:0]         tx_addr,
    input  logic               tx_wr,
    output logic [NIB-1:0]     ser_dout,
    output logic               ser_cout,
    input  logic [NIB-1:0]     ser_din,
    input  logic               ser_cin,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic [FRAME_W-1:0] rx_data,
    output logic [CTRL_W-1:0]  rx_ctrl,
    output logic [OVF_W-1:0]   rx_ovf,
`ifdef SYSTOLIC_LINK_PARITY_EN
    output logic               rx_perr,
`endif
    output logic [3:0]         beat
);

    logic [3:0]         beat_q, beat_d;
    logic               hfull_q, hfull_d;
    logic [FRAME_W-1:0] hdata_q, hdata_d;
    logic [CTRL_W-1:0]  hctrl_q, hctrl_d;
    logic [FRAME_W-1:0] txd_q, txd_d;
    logic [CTRL_W-1:0]  txc_q, txc_d;
    logic [CTRL_W-1:0]  tx_ctrl, idle_ctrl;
    logic               load, accept;

    assign load   = (beat_q == 4'(BEATS-1));
    assign accept = tx_valid && !hfull_q;

    always_comb begin
        tx_ctrl   = mk_ctrl(tx_addr, tx_wr, 1'b1);
        idle_ctrl = mk_ctrl(IDLE_ADR, 1'b0, 1'b0);
`ifdef SYSTOLIC_LINK_PARITY_EN
        tx_ctrl[CTRL_PAR]   = ^{tx_data, tx_ctrl};
        idle_ctrl[CTRL_PAR] = ^idle_ctrl;
`endif
    end

    always_comb begin
        beat_d  = beat_q + 4'd1;
        hfull_d = hfull_q;
        hdata_d = hdata_q;
        hctrl_d = hctrl_q;
        txd_d   = {txd_q[FRAME_W-NIB-1:0], {NIB{1'b0}}};
        txc_d   = {txc_q[CTRL_W-2:0], 1'b0};
        if (load) begin
            if (hfull_q) begin
                txd_d   = hdata_q;
                txc_d   = hctrl_q;
                hfull_d = 1'b0;
            end else begin
                txd_d = '0;
                txc_d = idle_ctrl;
            end
        end
        // An accept always targets the holding register, never the frame loading now.
        if (accept) begin
            hfull_d = 1'b1;
            hdata_d = tx_data;
            hctrl_d = tx_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_q  <= '0;
            hfull_q <= 1'b0;
            hdata_q <= '0;
            hctrl_q <= '0;
            txd_q   <= '0;
            txc_q   <= '0;
        end else begin
            beat_q  <= beat_d;
            hfull_q <= hfull_d;
            hdata_q <= hdata_d;
            hctrl_q <= hctrl_d;
            txd_q   <= txd_d;
            txc_q   <= txc_d;
        end
    end

    assign tx_ready = !hfull_q;
    assign ser_dout = txd_q[FRAME_W-1 -: NIB];
    assign ser_cout = txc_q[CTRL_W-1];
    assign beat     = beat_q;

    slink_deser #(
        .OVF_W(OVF_W)
    ) u_deser (
        .clk     (clk),
        .rst_n   (rst_n),
        .cap     (load),
        .ser_din (ser_din),
        .ser_cin (ser_cin),
        .rx_ready(rx_ready),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .rx_ctrl (rx_ctrl),
`ifdef SYSTOLIC_LINK_PARITY_EN
        .rx_perr (rx_perr),
`endif
        .rx_ovf  (rx_ovf)
    );

endmodule

// File: tb/tb_systolic_link_host.sv
// Directed bench for systolic_link_host with an RX scoreboard and loopback.
module tb_systolic_link_host;
    import systolic_link_pkg::*;

`ifdef SYSTOLIC_LINK_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_valid, tx_ready, tx_wr;
    logic [63:0] tx_data;
    logic [7:0]  tx_addr;
    logic [3:0]  ser_dout, ser_din;
    logic        ser_cout, ser_cin;
    logic        rx_valid, rx_ready;
    logic [63:0] rx_data;
    logic [15:0] rx_ctrl;
    logic [7:0]  rx_ovf;
    logic [3:0]  beat;
`ifdef SYSTOLIC_LINK_PARITY_EN
    logic        rx_perr;
`endif

    logic        lb;
    logic [3:0]  flip, din_drv;
    logic        cin_drv;

    always #5 clk = ~clk;

    assign ser_din = lb ? (ser_dout ^ flip) : din_drv;
    assign ser_cin = lb ? ser_cout : cin_drv;

    systolic_link_host #(.OVF_W(8), .IDLE_ADR(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_data(tx_data), .tx_addr(tx_addr), .tx_wr(tx_wr),
        .ser_dout(ser_dout), .ser_cout(ser_cout),
        .ser_din(ser_din), .ser_cin(ser_cin),
        .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_data(rx_data), .rx_ctrl(rx_ctrl), .rx_ovf(rx_ovf),
`ifdef SYSTOLIC_LINK_PARITY_EN
        .rx_perr(rx_perr),
`endif
        .beat(beat)
    );

    typedef struct packed {
        logic [63:0] d;
        logic [15:0] c;
    } exp_t;

    exp_t sb[$];
    bit   sb_on;
    int   tests = 0;
    int   fails = 0;

    function automatic logic [15:0] exp_ctrl(
        input logic [7:0] a, input logic wr, input logic fv, input logic [63:0] d
    );
        logic [15:0] c;
        c    = {a, 2'b00, wr, fv, 3'b000, 1'b0};
        c[0] = PAR_EN & (^{d, c});
        return c;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb_on && rx_valid) begin
            if (sb.size() == 0) begin
                chk("rx_unexpected_frame", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_rx_data", rx_data, e.d);
                chk("sb_rx_ctrl", {48'd0, rx_ctrl}, {48'd0, e.c});
            end
        end
    endtask

    task automatic wait_beat(input logic [3:0] b);
        int n;
        n = 0;
        while (beat !== b && n < 40) begin
            tick();
            n++;
        end
        if (beat !== b) chk("wait_beat_timeout", {60'd0, beat}, {60'd0, b});
    endtask

    task automatic send(input logic [63:0] d, input logic [7:0] a, input logic w);
        int n;
        n = 0;
        tx_valid = 1'b1;
        tx_data  = d;
        tx_addr  = a;
        tx_wr    = w;
        while (!tx_ready && n < 40) begin
            tick();
            n++;
        end
        if (!tx_ready) chk("send_timeout", {63'd0, tx_ready}, 64'd1);
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic cap_block(output logic [63:0] d, output logic [15:0] c);
        d = '0;
        c = '0;
        for (int j = 0; j < 16; j++) begin
            d = {d[59:0], ser_dout};
            c = {c[14:0], ser_cout};
            tick();
        end
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_tx_ready"}, {63'd0, tx_ready}, 64'd1);
        chk({p, "_ser_dout"}, {60'd0, ser_dout}, 64'd0);
        chk({p, "_ser_cout"}, {63'd0, ser_cout}, 64'd0);
        chk({p, "_rx_valid"}, {63'd0, rx_valid}, 64'd0);
        chk({p, "_rx_data"}, rx_data, 64'd0);
        chk({p, "_rx_ctrl"}, {48'd0, rx_ctrl}, 64'd0);
        chk({p, "_rx_ovf"}, {56'd0, rx_ovf}, 64'd0);
        chk({p, "_beat"}, {60'd0, beat}, 64'd0);
`ifdef SYSTOLIC_LINK_PARITY_EN
        chk({p, "_rx_perr"}, {63'd0, rx_perr}, 64'd0);
`endif
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d, p0, p1, p2, p3, p4, p5, p6, p7;
        logic [15:0] c;
        logic [4:0]  acc_ser;
        int          first_v, nv, acc;

        p0 = 64'h0123_4567_89AB_CDEF;
        p1 = 64'hA5A5_0001_1234_5678;
        p2 = 64'h0F0F_F0F0_1111_2222;
        p3 = 64'hDEAD_BEEF_CAFE_F00D;
        p4 = 64'h7777_0000_8888_0001;
        p5 = 64'h1357_9BDF_2468_ACE0;
        p6 = 64'hFFFF_0000_FFFF_0000;
        p7 = 64'hBADC_0FFE_E0DD_F00D;

        rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; tx_addr = '0; tx_wr = 1'b0;
        rx_ready = 1'b1; lb = 1'b0; flip = '0; din_drv = '0; cin_drv = 1'b0;
        sb_on = 1'b0;
        repeat (3) tick();
        chk_reset("rst");
        rst_n = 1'b1;

        // Idle link: all-zero serial output, first frame dropped, valid at clk 32
        first_v = -1; nv = 0; acc_ser = '0;
        for (int i = 1; i <= 48; i++) begin
            tick();
            acc_ser |= {ser_cout, ser_dout};
            if (i == 20) chk("beat_count", {60'd0, beat}, 64'd4);
            if (rx_valid) begin
                nv++;
                if (first_v < 0) begin
                    first_v = i;
                    chk("idle_rx_data", rx_data, 64'd0);
                    chk("idle_rx_ctrl", {48'd0, rx_ctrl}, 64'd0);
                end
            end
        end
        chk("idle_ser_zero", {59'd0, acc_ser}, 64'd0);
        chk("first_rx_valid_clk", 64'(first_v), 64'd32);
        chk("idle_rx_valid_count", 64'(nv), 64'd2);

        // Payload accepted at beat 3, serialised next block, looped back
        wait_beat(4'd3);
        chk("tx_ready_beat3", {63'd0, tx_ready}, 64'd1);
        tx_valid = 1'b1; tx_data = p0; tx_addr = ADR_PIPE0; tx_wr = 1'b1;
        tick();
        tx_valid = 1'b0;
        chk("tx_ready_held", {63'd0, tx_ready}, 64'd0);
        wait_beat(4'd0);
        chk("tx_ready_after_b15", {63'd0, tx_ready}, 64'd1);
        lb = 1'b1;
        sb.push_back('{d: p0, c: exp_ctrl(ADR_PIPE0, 1'b1, 1'b1, p0)});
        sb_on = 1'b1;
        cap_block(d, c);
        sb_on = 1'b0;
        chk("tx_ser_data", d, p0);
        chk("tx_ser_ctrl", {48'd0, c}, {48'd0, exp_ctrl(ADR_PIPE0, 1'b1, 1'b1, p0)});
        chk("sb_drained_t3", 64'(sb.size()), 64'd0);
        chk("loop_rx_valid", {63'd0, rx_valid}, 64'd1);
`ifdef SYSTOLIC_LINK_PARITY_EN
        chk("loop_rx_perr", {63'd0, rx_perr}, 64'd0);
`endif

        // Overrun: consumer stalls across three captures
        tick();
        send(p1, ADR_A, 1'b1);
        send(p2, ADR_B, 1'b0);
        send(p3, ADR_C0 + 8'd3, 1'b1);
        rx_ready = 1'b0;
        send(p4, ADR_PIPE0 + 8'd2, 1'b0);
        chk("ovf0_valid", {63'd0, rx_valid}, 64'd1);
        chk("ovf0_data", rx_data, p2);
        chk("ovf0_cnt", {56'd0, rx_ovf}, 64'd0);
        wait_beat(4'd0);
        chk("ovf1_data", rx_data, p3);
        chk("ovf1_cnt", {56'd0, rx_ovf}, 64'd1);
        tick();
        wait_beat(4'd0);
        chk("ovf2_data", rx_data, p4);
        chk("ovf2_ctrl", {48'd0, rx_ctrl},
            {48'd0, exp_ctrl(ADR_PIPE0 + 8'd2, 1'b0, 1'b1, p4)});
        chk("ovf2_cnt", {56'd0, rx_ovf}, 64'd2);
        repeat (5) tick();
        chk("ovf_valid_held", {63'd0, rx_valid}, 64'd1);
        rx_ready = 1'b1;
        tick();
        chk("ovf_valid_drop", {63'd0, rx_valid}, 64'd0);
        chk("ovf_cnt_keep", {56'd0, rx_ovf}, 64'd2);

        // Offer on beat 15 goes to the following frame
        wait_beat(4'd15);
        chk("tx_ready_b15", {63'd0, tx_ready}, 64'd1);
        tx_valid = 1'b1; tx_data = p5; tx_addr = ADR_STATE; tx_wr = 1'b0;
        tick();
        tx_valid = 1'b0;
        chk("b15_hold_full", {63'd0, tx_ready}, 64'd0);
        sb.push_back('{d: 64'd0, c: exp_ctrl(8'h00, 1'b0, 1'b0, 64'd0)});
        sb.push_back('{d: p5, c: exp_ctrl(ADR_STATE, 1'b0, 1'b1, p5)});
        sb_on = 1'b1;
        cap_block(d, c);
        chk("b15_cur_idle_data", d, 64'd0);
        chk("b15_cur_idle_ctrl", {48'd0, c}, {48'd0, exp_ctrl(8'h00, 1'b0, 1'b0, 64'd0)});
        cap_block(d, c);
        sb_on = 1'b0;
        chk("b15_next_data", d, p5);
        chk("sb_drained_t5", 64'(sb.size()), 64'd0);

        // Continuous offers: one accept per 16 clk
        tx_valid = 1'b1; tx_data = p6; tx_addr = ADR_B; tx_wr = 1'b1;
        acc = 0;
        for (int i = 0; i < 48; i++) begin
            if (tx_ready) acc++;
            tick();
        end
        tx_valid = 1'b0;
        chk("b2b_accepts", 64'(acc), 64'd3);

        // Reset mid-frame with a payload waiting
        send(p7, ADR_A, 1'b1);
        wait_beat(4'd7);
        chk("pre_rst_hold_full", {63'd0, tx_ready}, 64'd0);
        rst_n = 1'b0;
        tick();
        chk_reset("midrst");
        rst_n = 1'b1;
        acc_ser = '0;
        for (int i = 1; i <= 32; i++) begin
            flip = (i == 3) ? 4'b0001 : 4'b0000;
            tick();
            if (i == 1) chk("post_rst_beat", {60'd0, beat}, 64'd1);
            acc_ser |= {ser_cout, ser_dout};
        end
        flip = '0;
        chk("dropped_payload", {59'd0, acc_ser}, 64'd0);
        chk("post_rst_rx_valid", {63'd0, rx_valid}, 64'd1);
        chk("post_rst_rx_data", rx_data, 64'd0);
`ifdef SYSTOLIC_LINK_PARITY_EN
        chk("post_rst_perr", {63'd0, rx_perr}, 64'd0);
        send(p1, ADR_C0, 1'b1);
        wait_beat(4'd0);
        wait_beat(4'd5);
        flip = 4'b0100;
        tick();
        flip = '0;
        wait_beat(4'd0);
        chk("perr_valid", {63'd0, rx_valid}, 64'd1);
        chk("perr_flag", {63'd0, rx_perr}, 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
